// File: rtl/mdu_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on {acc, opd}: right-shifting shift-add for multiply,
// left-shifting restoring subtract for divide (quotient bits enter opd LSB).
module mdu_step
    import mdu_pkg::*;
(
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opd_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opd_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        acc_o  = acc_i;
        opd_o  = opd_i;
        sum    = {1'b0, acc_i} + ({1'b0, mcand_i} & {(WIDTH+1){opd_i[0]}});
        rem_sh = {acc_i, opd_i[WIDTH-1]};
        // Remainder after a successful subtract is below the divisor, so the low bits suffice.
        diff   = rem_sh[WIDTH-1:0] - mcand_i;
        if (is_div_i) begin
            if (rem_sh >= {1'b0, mcand_i}) begin
                acc_o = diff;
                opd_o = {opd_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[WIDTH-1:0];
                opd_o = {opd_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            opd_o = {sum[0], opd_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33 busy cycles per op,
// stalls EX on a new op or HI/LO read while a computation is in flight.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_read,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   step_acc, step_opd;
    logic [2*WIDTH-1:0] prod, prod_fix;

    mdu_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .mcand_i  (mcand_q),
        .acc_o    (step_acc),
        .opd_o    (step_opd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            a_q      <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        a_d      = a_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];
        prod     = {acc_q, opd_q};
        prod_fix = neg_q ? -prod : prod;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dbz_d    = op[1] && (b == '0);
                    a_d      = a;
                    acc_d    = '0;
                    // Multiply: opd holds the multiplier, mcand the multiplicand.
                    // Divide: opd holds the dividend, mcand the divisor.
                    opd_d    = op[1] ? (a_neg ? -a : a) : (b_neg ? -b : b);
                    mcand_d  = op[1] ? (b_neg ? -b : b) : (a_neg ? -a : a);
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    opd_d = step_opd;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dbz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_q  ? -opd_q : opd_q;
                        hi_d = rneg_q ? -acc_q : acc_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | hilo_read);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, hazards, cancel and reset.
module tb_mult_div_unit;

    logic        clk, rst, start, hilo_read, cancel;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mult_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hilo_read (hilo_read),
        .cancel    (cancel),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and observe 40 cycles after acceptance: busy cycles, done pulses, first done index.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bc, output int dc, output int da);
        @(negedge clk); start = 1'b1; op = o; a = x; b = y;
        @(negedge clk); start = 1'b0;
        bc = 0; dc = 0; da = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (da == 0) da = k;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hilo_read = 1'b0; cancel = 1'b0;
        #1;
        total_cnt++; if ({busy, done, stall} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, stall}); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult;
        int bc, dc, da;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_7x-3: got %h want ffffffffffffffeb", {hi, lo}); else pass_cnt++;
        total_cnt++; if (bc !== 33) $display("FAIL mult_busy_cycles: got %0d want 33", bc); else pass_cnt++;
        total_cnt++; if (dc !== 1) $display("FAIL mult_done_pulses: got %0d want 1", dc); else pass_cnt++;
        total_cnt++; if (da !== 34) $display("FAIL mult_done_latency: got %0d want 34", da); else pass_cnt++;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max: got %h want fffffffe00000001", {hi, lo}); else pass_cnt++;
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'h4000_0000_0000_0000) $display("FAIL mult_minxmin: got %h want 4000000000000000", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_div;
        int bc, dc, da;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_-7/2: got %h want fffffffffffffffd", {hi, lo}); else pass_cnt++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_min/-1: got %h want 0000000080000000", {hi, lo}); else pass_cnt++;
        run_op(2'b11, 32'd100, 32'd7, bc, dc, da);
        total_cnt++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_100/7: got %h want %h", {hi, lo}, {32'd2, 32'd14}); else pass_cnt++;
        total_cnt++; if (da !== 34) $display("FAIL div_done_latency: got %0d want 34", da); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int bc, dc, da;
        run_op(2'b11, 32'd100, 32'd0, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'h0000_0064_FFFF_FFFF) $display("FAIL divu_by0: got %h want 00000064ffffffff", {hi, lo}); else pass_cnt++;
        total_cnt++; if (da !== 34 || bc !== 33) $display("FAIL divu_by0_latency: got done@%0d busy=%0d want 34/33", da, bc); else pass_cnt++;
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, bc, dc, da);
        total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFB_FFFF_FFFF) $display("FAIL div_neg_by0: got %h want fffffffbffffffff", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_hilo_read;
        int bad, scyc, n;
        hilo_read = 1'b1; #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL idle_read_stall: got %b want 0", stall); else pass_cnt++;
        hilo_read = 1'b0;
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        hilo_read = 1'b1;
        bad = 0; scyc = 0; n = 0;
        forever begin
            #1;
            if (!busy || n >= 60) break;
            if (stall !== 1'b1) bad++;
            scyc++;
            @(negedge clk);
            n++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL read_wait_timeout: busy still %b", busy); else pass_cnt++;
        total_cnt++; if (bad !== 0 || scyc !== 29) $display("FAIL read_stall_span: got bad=%0d cycles=%0d want 0/29", bad, scyc); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL read_stall_release: got %b want 0", stall); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {32'd0, 32'd30}) $display("FAIL read_result: got %h want %h", {hi, lo}, {32'd0, 32'd30}); else pass_cnt++;
        @(negedge clk); hilo_read = 1'b0;
    endtask

    task automatic test_back_to_back;
        int bad, n, m;
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(negedge clk); op = 2'b11; a = 32'd100; b = 32'd7;
        bad = 0; n = 0;
        forever begin
            #1;
            if (!busy || n >= 60) break;
            if (stall !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        total_cnt++; if (bad !== 0 || n !== 33) $display("FAIL b2b_stall: got bad=%0d busy=%0d want 0/33", bad, n); else pass_cnt++;
        total_cnt++; if ({done, stall} !== 2'b10) $display("FAIL b2b_done_cycle: got done,stall=%b want 10", {done, stall}); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {32'd0, 32'd30}) $display("FAIL b2b_first: got %h want %h", {hi, lo}, {32'd0, 32'd30}); else pass_cnt++;
        @(negedge clk); start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy); else pass_cnt++;
        m = 1;
        while (!done && m < 60) begin
            @(negedge clk);
            m++;
        end
        total_cnt++; if (m !== 34) $display("FAIL b2b_second_latency: got %0d want 34", m); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL b2b_second: got %h want %h", {hi, lo}, {32'd2, 32'd14}); else pass_cnt++;
    endtask

    task automatic test_cancel;
        int dc;
        @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", busy); else pass_cnt++;
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        total_cnt++; if (dc !== 0) $display("FAIL cancel_no_done: got %0d pulses want 0", dc); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL cancel_hilo_kept: got %h want %h", {hi, lo}, {32'd2, 32'd14}); else pass_cnt++;
        start = 1'b1; cancel = 1'b1; op = 2'b00;
        @(negedge clk); start = 1'b0; cancel = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cancel_start_idle: got busy=%b want 0", busy); else pass_cnt++;
        for (int k = 0; k < 40; k++) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bc, dc, da;
        @(negedge clk); start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 20; k++) @(negedge clk);
        rst = 1'b1; #1;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {busy, done}); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        run_op(2'b00, 32'd3, 32'd4, bc, dc, da);
        total_cnt++; if ({hi, lo} !== {32'd0, 32'd12}) $display("FAIL rst_then_mult: got %h want %h", {hi, lo}, {32'd0, 32'd12}); else pass_cnt++;
        total_cnt++; if (dc !== 1 || da !== 34) $display("FAIL rst_then_mult_done: got pulses=%0d at %0d want 1 at 34", dc, da); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_hilo_read;
        test_back_to_back;
        test_cancel;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
